// File: rtl/vcve2_vadd_sequencer_if.sv
// ---------------------------------------------------------------------------
// vcve2_vadd_sequencer_if
//   Bundle of every signal between the vector-add sequencer and its
//   neighbours: the decode stage (req_*), the register-file read port (rd_*),
//   the shared fracturable adder (add_*), the register-file write port (wr_*)
//   and the status flags (busy_o, done_o).
//
//   modport master : the sequencer itself (drives every *_o signal)
//   modport slave  : the surrounding environment (drives every *_i signal)
//
//   VLEN must match the VLEN of the sequencer instance that uses it.
// ---------------------------------------------------------------------------
interface vcve2_vadd_sequencer_if #(
  parameter int VLEN = 128
);
  localparam int NBEATS = VLEN / 32;
  localparam int IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int VL_W   = $clog2(VLEN / 8) + 1;

  // Request from decode
  logic              req_valid_i;
  logic              req_ready_o;
  logic [VL_W-1:0]   req_vl_i;
  logic [1:0]        req_sew_i;
  // Register-file read port (combinational read)
  logic [IDX_W-1:0]  rd_beat_o;
  logic [31:0]       rd_a_i;
  logic [31:0]       rd_b_i;
  // Shared adder, vector mode
  logic [32:0]       add_op_a_o;
  logic [32:0]       add_op_b_o;
  logic [1:0]        add_sew_o;
  logic [33:0]       add_res_i;
  // Register-file write port
  logic              wr_valid_o;
  logic              wr_ready_i;
  logic [IDX_W-1:0]  wr_beat_o;
  logic [31:0]       wr_data_o;
  logic [3:0]        wr_be_o;
  // Status
  logic              busy_o;
  logic              done_o;

  modport master (
    input  req_valid_i, req_vl_i, req_sew_i, rd_a_i, rd_b_i, add_res_i, wr_ready_i,
    output req_ready_o, rd_beat_o, add_op_a_o, add_op_b_o, add_sew_o,
           wr_valid_o, wr_beat_o, wr_data_o, wr_be_o, busy_o, done_o
  );

  modport slave (
    output req_valid_i, req_vl_i, req_sew_i, rd_a_i, rd_b_i, add_res_i, wr_ready_i,
    input  req_ready_o, rd_beat_o, add_op_a_o, add_op_b_o, add_sew_o,
           wr_valid_o, wr_beat_o, wr_data_o, wr_be_o, busy_o, done_o
  );
endinterface

// File: rtl/vcve2_vadd_sequencer.sv
// ---------------------------------------------------------------------------
// vcve2_vadd_sequencer
//   Runs vd = vs1 + vs2 through the shared 33-bit fracturable adder, one
//   32-bit beat per cycle, and streams the sums to the register file through
//   a registered, byte-masked write port with back-pressure.
//
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous, active-high reset
//   bus    : vcve2_vadd_sequencer_if.master
//            req_*  request handshake (vl, sew) from decode
//            rd_*   beat index out, vs2/vs1 beat data in (same cycle)
//            add_*  adder operands {data,1'b0}, sew, result (sum in [32:1])
//            wr_*   registered write beat: valid/ready, beat, data, byte enables
//            busy_o not IDLE; done_o one-cycle completion pulse
// ---------------------------------------------------------------------------
module vcve2_vadd_sequencer #(
  parameter int VLEN       = 128,
  parameter int PIPE_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  vcve2_vadd_sequencer_if.master bus
);
  localparam int NBEATS = VLEN / PIPE_WIDTH;
  localparam int IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int VL_W   = $clog2(VLEN / 8) + 1;
  localparam int BE_W   = PIPE_WIDTH / 8;

  localparam logic [VL_W-1:0] VLEN_BYTES = VL_W'(VLEN / 8);
  localparam logic [VL_W-1:0] BEAT_BYTES = VL_W'(BE_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [1:0]            sew_q, sew_d;
  logic [VL_W-1:0]       nbytes_q, nbytes_d;
  logic                  wr_valid_q, wr_valid_d;
  logic [IDX_W-1:0]      wr_beat_q, wr_beat_d;
  logic [PIPE_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [BE_W-1:0]       wr_be_q, wr_be_d;

  // Request decode: sew 11 behaves as 10, vl is clamped to VLMAX.
  logic [1:0]      req_sew_eff;
  logic [VL_W-1:0] req_vlmax;
  logic [VL_W-1:0] req_vl_eff;
  logic [VL_W-1:0] req_nbytes;

  // Current beat geometry in bytes.
  logic [VL_W-1:0]       beat_base;
  logic [BE_W-1:0]       beat_be;
  logic                  beat_last;
  logic [PIPE_WIDTH-1:0] beat_sum;
  logic                  out_free;
  logic                  wr_fire;

  // Guard bit and carry-out of the adder result are not part of the sum.
  logic unused_res;
  assign unused_res = ^{bus.add_res_i[PIPE_WIDTH+1], bus.add_res_i[0]};

  always_comb begin
    req_sew_eff = (bus.req_sew_i == 2'b11) ? 2'b10 : bus.req_sew_i;
    req_vlmax   = VLEN_BYTES >> req_sew_eff;
    req_vl_eff  = (bus.req_vl_i > req_vlmax) ? req_vlmax : bus.req_vl_i;
    req_nbytes  = req_vl_eff << req_sew_eff;
  end

  always_comb begin
    beat_base = VL_W'({rd_ptr_q, 2'b00});
    beat_be   = '0;
    for (int j = 0; j < BE_W; j++) begin
      beat_be[j] = (beat_base + VL_W'(j)) < nbytes_q;
    end
    // This beat holds the final active byte when the next beat would start
    // at or beyond the byte count.
    beat_last = (beat_base + BEAT_BYTES) >= nbytes_q;
    beat_sum  = bus.add_res_i[PIPE_WIDTH:1];
  end

  assign out_free = !wr_valid_q || bus.wr_ready_i;
  assign wr_fire  = wr_valid_q && bus.wr_ready_i;

  // NOTE: every signal assigned here gets its hold value first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    sew_d      = sew_q;
    nbytes_d   = nbytes_q;
    wr_valid_d = wr_valid_q;
    wr_beat_d  = wr_beat_q;
    wr_data_d  = wr_data_q;
    wr_be_d    = wr_be_q;

    if (wr_fire) begin
      wr_valid_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid_i) begin
          sew_d    = req_sew_eff;
          nbytes_d = req_nbytes;
          rd_ptr_d = '0;
          state_d  = (req_nbytes == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // A stalled output register freezes the read pointer, so the same
        // beat keeps being presented to the adder until it can be captured.
        if (out_free) begin
          wr_valid_d = 1'b1;
          wr_data_d  = beat_sum;
          wr_beat_d  = rd_ptr_q;
          wr_be_d    = beat_be;
          if (beat_last) begin
            rd_ptr_d = '0;
            state_d  = S_DRAIN;
          end else begin
            rd_ptr_d = rd_ptr_q + IDX_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (wr_fire) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      rd_ptr_q   <= '0;
      sew_q      <= '0;
      nbytes_q   <= '0;
      wr_valid_q <= 1'b0;
      wr_beat_q  <= '0;
      wr_data_q  <= '0;
      wr_be_q    <= '0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      sew_q      <= sew_d;
      nbytes_q   <= nbytes_d;
      wr_valid_q <= wr_valid_d;
      wr_beat_q  <= wr_beat_d;
      wr_data_q  <= wr_data_d;
      wr_be_q    <= wr_be_d;
    end
  end

  // Operands are only driven while beats are being read, keeping the adder
  // quiet in the other states.
  assign bus.req_ready_o = (state_q == S_IDLE);
  assign bus.busy_o      = (state_q != S_IDLE);
  assign bus.done_o      = (state_q == S_DONE);
  assign bus.rd_beat_o   = (state_q == S_RUN) ? rd_ptr_q : '0;
  assign bus.add_op_a_o  = (state_q == S_RUN) ? {bus.rd_a_i, 1'b0} : '0;
  assign bus.add_op_b_o  = (state_q == S_RUN) ? {bus.rd_b_i, 1'b0} : '0;
  assign bus.add_sew_o   = sew_q;
  assign bus.wr_valid_o  = wr_valid_q;
  assign bus.wr_beat_o   = wr_beat_q;
  assign bus.wr_data_o   = wr_data_q;
  assign bus.wr_be_o     = wr_be_q;
endmodule

// File: tb/tb_vcve2_vadd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vcve2_vadd_sequencer
//   Directed bench for vcve2_vadd_sequencer at VLEN=128. The bench plays the
//   register file (combinational read from a_mem/b_mem) and the fracturable
//   adder (lane-split add by add_sew_o). Inputs change and outputs are
//   sampled on the falling edge; the DUT acts on the rising edge.
// ---------------------------------------------------------------------------
module tb_vcve2_vadd_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] a_mem [4];
  logic [31:0] b_mem [4];
  logic [31:0] exp_q [4];

  always #5 clk = ~clk;

  vcve2_vadd_sequencer_if #(.VLEN(128)) bus ();

  vcve2_vadd_sequencer #(
    .VLEN      (128),
    .PIPE_WIDTH(32)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  // Adder model: carries stop at element boundaries chosen by sew.
  function automatic logic [31:0] lane_add(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] sew);
    logic [31:0] s;
    s = '0;
    case (sew)
      2'b00:   for (int i = 0; i < 4; i++) s[i*8 +: 8] = a[i*8 +: 8] + b[i*8 +: 8];
      2'b01:   for (int i = 0; i < 2; i++) s[i*16 +: 16] = a[i*16 +: 16] + b[i*16 +: 16];
      default: s = a + b;
    endcase
    return s;
  endfunction

  assign bus.rd_a_i    = a_mem[bus.rd_beat_o];
  assign bus.rd_b_i    = b_mem[bus.rd_beat_o];
  assign bus.add_res_i = {1'b0, lane_add(bus.add_op_a_o[32:1], bus.add_op_b_o[32:1],
                                         bus.add_sew_o), 1'b0};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic exp_wr(input string tag, input logic v, input logic [1:0] beat,
                        input logic [31:0] data, input logic [3:0] be);
    check({tag, ".valid"}, bus.wr_valid_o, v);
    check({tag, ".done"}, bus.done_o, 1'b0);
    if (v) begin
      check({tag, ".beat"}, bus.wr_beat_o, beat);
      check({tag, ".data"}, bus.wr_data_o, data);
      check({tag, ".be"}, bus.wr_be_o, be);
    end
  endtask

  // Issues a request at cycle T; returns at cycle T+1.
  task automatic request(input logic [4:0] vl, input logic [1:0] sew);
    check("req_ready", bus.req_ready_o, 1'b1);
    bus.req_valid_i = 1'b1;
    bus.req_vl_i    = vl;
    bus.req_sew_i   = sew;
    tick();
    bus.req_valid_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".req_ready"}, bus.req_ready_o, 1'b1);
    check({tag, ".busy"}, bus.busy_o, 1'b0);
    check({tag, ".done"}, bus.done_o, 1'b0);
    check({tag, ".wr_valid"}, bus.wr_valid_o, 1'b0);
    check({tag, ".wr_beat"}, bus.wr_beat_o, 2'd0);
    check({tag, ".wr_data"}, bus.wr_data_o, 32'h0);
    check({tag, ".wr_be"}, bus.wr_be_o, 4'h0);
    check({tag, ".rd_beat"}, bus.rd_beat_o, 2'd0);
    check({tag, ".op_a"}, bus.add_op_a_o, 33'h0);
    check({tag, ".op_b"}, bus.add_op_b_o, 33'h0);
    check({tag, ".sew"}, bus.add_sew_o, 2'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req_valid_i = 1'b0;
    bus.req_vl_i    = '0;
    bus.req_sew_i   = '0;
    bus.wr_ready_i  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a_mem[k] = '0;
      b_mem[k] = '0;
      exp_q[k] = '0;
    end

    // ---- Reset values
    #1 rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    tick();

    // ---- sew=32, vl=4: 0xFFFFFFFF + 1 wraps to 0 in every beat
    for (int k = 0; k < 4; k++) begin
      a_mem[k] = 32'hFFFF_FFFF;
      b_mem[k] = 32'h0000_0001;
    end
    request(5'd4, 2'b10);
    check("t1.rd_beat", bus.rd_beat_o, 2'd0);
    check("t1.op_a", bus.add_op_a_o, 33'h1_FFFF_FFFE);
    check("t1.op_b", bus.add_op_b_o, 33'h0_0000_0002);
    check("t1.sew", bus.add_sew_o, 2'b10);
    check("t1.busy", bus.busy_o, 1'b1);
    check("t1.req_ready", bus.req_ready_o, 1'b0);
    exp_wr("t1.T1", 1'b0, 2'd0, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_wr($sformatf("t1.beat%0d", k), 1'b1, 2'(k), 32'h0, 4'hF);
    end
    tick();
    check("t1.done", bus.done_o, 1'b1);
    check("t1.done_valid", bus.wr_valid_o, 1'b0);
    tick();
    check("t1.done_clear", bus.done_o, 1'b0);

    // ---- sew=8, vl=5: byte lanes 0x80+0x80 with no inter-byte carry
    for (int k = 0; k < 4; k++) begin
      a_mem[k] = 32'h8080_8080;
      b_mem[k] = 32'h8080_8080;
    end
    request(5'd5, 2'b00);
    check("t2.sew", bus.add_sew_o, 2'b00);
    check("t2.rd_beat", bus.rd_beat_o, 2'd0);
    tick();
    exp_wr("t2.beat0", 1'b1, 2'd0, 32'h0, 4'hF);
    tick();
    exp_wr("t2.beat1", 1'b1, 2'd1, 32'h0, 4'h1);
    tick();
    check("t2.done", bus.done_o, 1'b1);
    check("t2.no_beat2", bus.wr_valid_o, 1'b0);
    tick();

    // ---- sew=16, vl=20 clamped to 8 elements: 4 full beats
    a_mem[0] = 32'h0001_FFFF; b_mem[0] = 32'h0000_0001; exp_q[0] = 32'h0001_0000;
    a_mem[1] = 32'hFFFF_0001; b_mem[1] = 32'h0002_0002; exp_q[1] = 32'h0001_0003;
    a_mem[2] = 32'h1234_5678; b_mem[2] = 32'h1111_1111; exp_q[2] = 32'h2345_6789;
    a_mem[3] = 32'h7FFF_8000; b_mem[3] = 32'h8001_8000; exp_q[3] = 32'h0000_0000;
    request(5'd20, 2'b01);
    check("t3.sew", bus.add_sew_o, 2'b01);
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_wr($sformatf("t3.beat%0d", k), 1'b1, 2'(k), exp_q[k], 4'hF);
    end
    tick();
    check("t3.done", bus.done_o, 1'b1);
    tick();

    // ---- sew=32, vl=4, write stalled for 3 cycles at beat 1
    for (int k = 0; k < 4; k++) begin
      a_mem[k] = 32'h1111_1111 * (k + 1);
      b_mem[k] = 32'h0000_0001;
    end
    exp_q[0] = 32'h1111_1112; exp_q[1] = 32'h2222_2223;
    exp_q[2] = 32'h3333_3334; exp_q[3] = 32'h4444_4445;
    request(5'd4, 2'b10);                       // now T+1
    tick();                                     // T+2
    exp_wr("t4.beat0", 1'b1, 2'd0, exp_q[0], 4'hF);
    tick();                                     // T+3
    exp_wr("t4.beat1", 1'b1, 2'd1, exp_q[1], 4'hF);
    check("t4.rd_hold.T3", bus.rd_beat_o, 2'd2);
    bus.wr_ready_i  = 1'b0;
    bus.req_valid_i = 1'b1;                     // must be ignored while busy
    bus.req_vl_i    = 5'd0;
    for (int c = 4; c <= 6; c++) begin
      tick();                                   // T+4..T+6
      exp_wr($sformatf("t4.stall.T%0d", c), 1'b1, 2'd1, exp_q[1], 4'hF);
      check($sformatf("t4.rd_hold.T%0d", c), bus.rd_beat_o, 2'd2);
      check($sformatf("t4.busy.T%0d", c), bus.busy_o, 1'b1);
      check($sformatf("t4.req_ready.T%0d", c), bus.req_ready_o, 1'b0);
    end
    bus.wr_ready_i  = 1'b1;
    bus.req_valid_i = 1'b0;
    tick();                                     // T+7
    exp_wr("t4.beat2", 1'b1, 2'd2, exp_q[2], 4'hF);
    tick();                                     // T+8
    exp_wr("t4.beat3", 1'b1, 2'd3, exp_q[3], 4'hF);
    tick();                                     // T+9
    check("t4.done", bus.done_o, 1'b1);
    tick();

    // ---- vl=0: straight to DONE, no write
    request(5'd0, 2'b10);
    check("t5.done", bus.done_o, 1'b1);
    check("t5.busy", bus.busy_o, 1'b1);
    check("t5.wr_valid", bus.wr_valid_o, 1'b0);
    tick();
    check("t5.req_ready", bus.req_ready_o, 1'b1);
    check("t5.done_clear", bus.done_o, 1'b0);
    check("t5.wr_valid2", bus.wr_valid_o, 1'b0);

    // ---- reset pulsed during beat 2, then a clean rerun
    request(5'd4, 2'b10);
    tick();
    exp_wr("t6.beat0", 1'b1, 2'd0, exp_q[0], 4'hF);
    tick();
    exp_wr("t6.beat1", 1'b1, 2'd1, exp_q[1], 4'hF);
    tick();
    exp_wr("t6.beat2", 1'b1, 2'd2, exp_q[2], 4'hF);
    rst = 1'b1;
    #1;
    check_reset_outputs("t6.midreset");
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("t6.idle", bus.busy_o, 1'b0);
    request(5'd4, 2'b10);
    check("t6.rerun.rd_beat", bus.rd_beat_o, 2'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_wr($sformatf("t6.rerun.beat%0d", k), 1'b1, 2'(k), exp_q[k], 4'hF);
    end
    tick();
    check("t6.rerun.done", bus.done_o, 1'b1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
